// File: rtl/wb_slave_register.sv
// Wishbone B4 classic-cycle register bank with byte-lane writes and a single-wait-state ACK.
// Optional WB_SLAVE_REGISTER_ERR_EN adds err_o, raised instead of ack_o for out-of-range accesses.
module wb_slave_register #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int GRANULE    = 8,
  parameter int NUM_REGS   = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [ADDR_WIDTH-1:0]            adr_i,
  input  logic [DATA_WIDTH-1:0]            dat_i,
  output logic [DATA_WIDTH-1:0]            dat_o,
  input  logic [(DATA_WIDTH/GRANULE)-1:0]  sel_i,
  input  logic                             we_i,
  input  logic                             cyc_i,
  input  logic                             stb_i,
  output logic                             ack_o
`ifdef WB_SLAVE_REGISTER_ERR_EN
  ,
  output logic                             err_o
`endif
);

  localparam int SEL_WIDTH = DATA_WIDTH / GRANULE;
  localparam int OFFS_BITS = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 0;
  localparam int IDX_BITS  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic [DATA_WIDTH-1:0] regs_r [NUM_REGS];
  logic [DATA_WIDTH-1:0] dat_r;
  logic                  ack_r;
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [IDX_BITS-1:0]   idx_s;
  logic                  in_range_s;
  logic                  req_s;
  logic [DATA_WIDTH-1:0] mask_s;
  logic [DATA_WIDTH-1:0] cur_s;

  // Expand the per-lane select into a bit mask over the data word.
  function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [SEL_WIDTH-1:0] sel);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int k = 0; k < SEL_WIDTH; k++) begin
      m[k*GRANULE +: GRANULE] = {GRANULE{sel[k]}};
    end
    return m;
  endfunction

  // Replace only the selected lanes of the old word with the new data.
  function automatic logic [DATA_WIDTH-1:0] lane_merge(input logic [DATA_WIDTH-1:0] old_w,
                                                        input logic [DATA_WIDTH-1:0] new_w,
                                                        input logic [DATA_WIDTH-1:0] m);
    return (old_w & ~m) | (new_w & m);
  endfunction

  assign word_idx_s = adr_i >> OFFS_BITS;
  assign idx_s      = word_idx_s[IDX_BITS-1:0];
  assign in_range_s = (word_idx_s < ADDR_WIDTH'(NUM_REGS));
  assign req_s      = cyc_i & stb_i & ~ack_r;
  assign mask_s     = lane_mask(sel_i);

  // Current contents of the addressed register; zero when the address is outside the bank.
  always_comb begin
    cur_s = '0;
    if (in_range_s) begin
      cur_s = regs_r[idx_s];
    end else begin
      cur_s = '0;
    end
  end

`ifdef WB_SLAVE_REGISTER_ERR_EN
  logic err_r;

  // Remember whether the pending acknowledge belongs to an out-of-range access.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      err_r <= 1'b0;
    end else if (req_s) begin
      err_r <= ~in_range_s;
    end else begin
      err_r <= err_r;
    end
  end

  assign ack_o = ack_r & cyc_i & stb_i & ~err_r;
  assign err_o = ack_r & cyc_i & stb_i & err_r;
`else
  assign ack_o = ack_r & cyc_i & stb_i;
`endif

  // Acknowledge flag, read data register and register bank; reset overrides any access.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ack_r <= 1'b0;
      dat_r <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= '0;
      end
    end else if (req_s) begin
      ack_r <= 1'b1;
      if (we_i) begin
        if (in_range_s) begin
          regs_r[idx_s] <= lane_merge(regs_r[idx_s], dat_i, mask_s);
        end
      end else begin
`ifdef WB_SLAVE_REGISTER_ERR_EN
        if (in_range_s) begin
          dat_r <= cur_s & mask_s;
        end
`else
        dat_r <= cur_s & mask_s;
`endif
      end
    end else begin
      ack_r <= 1'b0;
    end
  end

  assign dat_o = dat_r;

endmodule

// File: tb/tb_wb_slave_register.sv
// Directed self-checking bench for wb_slave_register (DATA_WIDTH=32, NUM_REGS=16).
// Handles both builds of WB_SLAVE_REGISTER_ERR_EN.
module tb_wb_slave_register;

  logic        clk_i;
  logic        rst_i;
  logic [15:0] adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o;
  logic [3:0]  sel_i;
  logic        we_i;
  logic        cyc_i;
  logic        stb_i;
  logic        ack_o;
  logic        err_s;

  int total;
  int bad;

  wb_slave_register #(
    .ADDR_WIDTH(16), .DATA_WIDTH(32), .GRANULE(8), .NUM_REGS(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .adr_i(adr_i), .dat_i(dat_i), .dat_o(dat_o),
    .sel_i(sel_i), .we_i(we_i), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o)
`ifdef WB_SLAVE_REGISTER_ERR_EN
    , .err_o(err_s)
`endif
  );

`ifndef WB_SLAVE_REGISTER_ERR_EN
  assign err_s = 1'b0;
`endif

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // One classic-cycle transfer; returns what the bus showed at the terminating cycle.
  task automatic wb_xfer(input logic w, input logic [15:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic keep_cyc,
                         output logic [31:0] rdata, output int waits,
                         output logic acked, output logic erred);
    @(posedge clk_i); #1;
    we_i = w; adr_i = a; sel_i = s; dat_i = d; cyc_i = 1'b1; stb_i = 1'b1;
    waits = 0; acked = 1'b0; erred = 1'b0; rdata = 32'h0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk_i);
      if (ack_o || err_s) begin
        acked = ack_o; erred = err_s; rdata = dat_o;
        break;
      end
      waits++;
    end
    @(posedge clk_i); #1;
    stb_i = 1'b0; we_i = 1'b0;
    if (!keep_cyc) cyc_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] rd; int w; logic ak, er;
    rst_i = 1'b0; cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1;
    adr_i = 16'h0000; sel_i = 4'hF; dat_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk_i);
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", ack_o); end
    total++;
    if (dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h exp=00000000", dat_o); end
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; rst_i = 1'b1;
    wb_xfer(1'b0, 16'h0000, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (w !== 1) begin bad++; $display("FAIL first_read_waits got=%0d exp=1", w); end
    total++;
    if (ak !== 1'b1) begin bad++; $display("FAIL first_read_ack got=%b exp=1", ak); end
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL first_read_dat got=%h exp=00000000", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd; int w; logic ak, er;
    wb_xfer(1'b1, 16'h0004, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, w, ak, er);
    total++;
    if (ak !== 1'b1) begin bad++; $display("FAIL write_ack got=%b exp=1", ak); end
    wb_xfer(1'b0, 16'h0004, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'hDEAD_BEEF) begin bad++; $display("FAIL full_write got=%h exp=deadbeef", rd); end
    wb_xfer(1'b1, 16'h0004, 4'h2, 32'h0000_AA00, 1'b0, rd, w, ak, er);
    wb_xfer(1'b0, 16'h0004, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL lane1_write got=%h exp=deadaaef", rd); end
    wb_xfer(1'b0, 16'h0006, 4'h3, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'h0000_AAEF) begin bad++; $display("FAIL partial_read got=%h exp=0000aaef", rd); end
  endtask

  task automatic test_sel_zero();
    logic [31:0] rd; int w; logic ak, er;
    wb_xfer(1'b1, 16'h0004, 4'h0, 32'hFFFF_FFFF, 1'b0, rd, w, ak, er);
    total++;
    if (ak !== 1'b1) begin bad++; $display("FAIL sel0_write_ack got=%b exp=1", ak); end
    wb_xfer(1'b0, 16'h0004, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL sel0_no_change got=%h exp=deadaaef", rd); end
    wb_xfer(1'b0, 16'h0004, 4'h0, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL sel0_read got=%h exp=00000000", rd); end
  endtask

  task automatic test_rmw();
    logic [31:0] rd; int w; logic ak, er;
    wb_xfer(1'b1, 16'h0008, 4'hF, 32'h1234_5678, 1'b0, rd, w, ak, er);
    wb_xfer(1'b0, 16'h0008, 4'hF, 32'h0, 1'b1, rd, w, ak, er);
    total++;
    if (rd !== 32'h1234_5678) begin bad++; $display("FAIL rmw_read got=%h exp=12345678", rd); end
    total++;
    if (cyc_i !== 1'b1 || stb_i !== 1'b0) begin
      bad++; $display("FAIL rmw_gap got=cyc%b_stb%b exp=cyc1_stb0", cyc_i, stb_i);
    end
    wb_xfer(1'b1, 16'h0008, 4'hF, 32'hCAFE_F00D, 1'b0, rd, w, ak, er);
    total++;
    if (ak !== 1'b1 || w !== 1) begin bad++; $display("FAIL rmw_write_ack got=%b/%0d exp=1/1", ak, w); end
    wb_xfer(1'b0, 16'h0008, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'hCAFE_F00D) begin bad++; $display("FAIL rmw_result got=%h exp=cafef00d", rd); end
  endtask

  task automatic test_back_to_back();
    logic [5:0] seen;
    @(posedge clk_i); #1;
    we_i = 1'b0; adr_i = 16'h0004; sel_i = 4'hF; cyc_i = 1'b1; stb_i = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk_i);
      seen[n] = ack_o;
    end
    @(posedge clk_i); #1;
    cyc_i = 1'b0; stb_i = 1'b0;
    total++;
    if (seen !== 6'b101010) begin bad++; $display("FAIL b2b_ack_pattern got=%b exp=101010", seen); end
  endtask

  task automatic test_abort();
    logic [31:0] rd; int w; logic ak, er;
    @(posedge clk_i); #1;
    we_i = 1'b1; adr_i = 16'h000C; sel_i = 4'hF; dat_i = 32'h1111_1111; cyc_i = 1'b1; stb_i = 1'b1;
    @(posedge clk_i); #1;
    stb_i = 1'b0;
    @(negedge clk_i);
    total++;
    if (ack_o !== 1'b0) begin bad++; $display("FAIL abort_ack got=%b exp=0", ack_o); end
    cyc_i = 1'b0; we_i = 1'b0;
    wb_xfer(1'b0, 16'h000C, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'h1111_1111) begin bad++; $display("FAIL abort_committed got=%h exp=11111111", rd); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int w; logic ak, er;
    wb_xfer(1'b0, 16'h0004, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL oor_pre_read got=%h exp=deadaaef", rd); end
    wb_xfer(1'b0, 16'h0040, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
`ifdef WB_SLAVE_REGISTER_ERR_EN
    total++;
    if (er !== 1'b1 || ak !== 1'b0) begin bad++; $display("FAIL oor_err got=err%b_ack%b exp=err1_ack0", er, ak); end
    total++;
    if (rd !== 32'hDEAD_AAEF) begin bad++; $display("FAIL oor_dat_hold got=%h exp=deadaaef", rd); end
`else
    total++;
    if (ak !== 1'b1 || er !== 1'b0) begin bad++; $display("FAIL oor_ack got=ack%b_err%b exp=ack1_err0", ak, er); end
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL oor_read got=%h exp=00000000", rd); end
`endif
    wb_xfer(1'b1, 16'h0040, 4'hF, 32'h5555_5555, 1'b0, rd, w, ak, er);
    wb_xfer(1'b0, 16'h0000, 4'hF, 32'h0, 1'b0, rd, w, ak, er);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL oor_write_ignored got=%h exp=00000000", rd); end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_i = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
    adr_i = 16'h0; sel_i = 4'h0; dat_i = 32'h0;
    test_reset();
    test_byte_lanes();
    test_sel_zero();
    test_rmw();
    test_back_to_back();
    test_abort();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
